instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of the 32-bit MIPS datapath.
- Issues word reads to a multi-cycle instruction memory over a req/ack handshake and buffers the returned words with their PCs in a DEPTH-entry queue.
- Presents each instruction to the datapath with a valid/ready handshake.
- Discards queued and in-flight fetches when the datapath redirects the PC on a taken branch or jump.

Parameters:
- n, 32, data/address width.
- DEPTH, 4, queue entries; power of 2, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- redirect  input  1  datapath requests a fetch restart (taken branch/jump).
- redirect_pc  input  n  restart address; bits [1:0] ignored and forced to 0.
- instr_ready  input  1  datapath consumes the head entry this cycle.
- instr  output  n  head instruction word; 0 when instr_valid=0.
- instr_pc  output  n  byte address of instr; 0 when instr_valid=0.
- instr_valid  output  1  queue non-empty.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  n  word-aligned request address.
- mem_rdata  input  n  read data, valid in the cycle mem_ack=1.
- mem_ack  input  1  one-cycle completion strobe for the outstanding request.

Behaviour:
- Reset values: instr_valid=0, instr=0, instr_pc=0, mem_req=0, mem_addr=RESET_PC, count=0, state=IDLE, fetch pc fpc=RESET_PC.
- Outputs are registered or decoded from registers only; there is no combinational path from any input to any output.
- At most one memory request is outstanding.
- Handshake rule: once mem_req rises, it and mem_addr hold stable until the cycle mem_ack=1.
- FSM states:
  - IDLE:
    - redirect → fpc<=redirect_pc, flush, stay IDLE.
    - Otherwise count<DEPTH → REQ with mem_addr<=fpc.
  - REQ (mem_req=1):
    - ack without redirect → push {mem_rdata, mem_addr} and fpc<=fpc+4. Then either go to REQ with mem_addr<=fpc+4 if the post-push count<DEPTH (back-to-back fetch), or go to IDLE.
    - redirect with ack in the same cycle → drop the data, flush, fpc<=redirect_pc, go to IDLE.
    - redirect without ack → flush, fpc<=redirect_pc, go to DRAIN.
  - DRAIN (mem_req=1, old address):
    - Waits for the ack; the returned data is discarded.
    - On ack → IDLE.
    - A redirect while in DRAIN overwrites fpc and flushes again; stay in DRAIN unless ack arrives in the same cycle, in which case go to IDLE.
- Queue:
  - pop = instr_valid & instr_ready.
  - push and pop in the same cycle → count unchanged.
  - A request is issued only when count<DEPTH, so a push never overflows.
  - Read/write pointers wrap mod DEPTH.
  - Push into an empty queue at edge t → instr_valid=1 after edge t (one-cycle ack-to-valid latency).
- Priority: redirect > push/pop. On redirect, count<=0, both pointers<=0, and instr_valid=0 on the next cycle; any pop that cycle is ignored.
- Arithmetic: fpc+4 wraps modulo 2^n, so 32'hFFFF_FFFC+4 = 0.
- Reset mid-request: mem_req drops immediately (asynchronous). Memory must tolerate an abandoned request.
- instr_ready while instr_valid=0 has no effect.

Decomposition:
- Package fetch_pkg:
  - typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_t.
  - localparam WORD_BYTES=4.
  - typedef struct packed {logic [31:0] word; logic [31:0] pc;} fetch_entry_t.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty, full, and async reset.
- The FSM, fpc register, and memory interface live in instr_fetch_queue.

Test Plan:
- Reset release, mem_ack 2 cycles after each mem_req, mem_rdata=32'h0C0D000F then 32'h0C0D000A, instr_ready=1 → mem_addr 0 then 4; instr_valid one cycle after each ack with instr_pc 0 and 4, in order.
- instr_ready=0 and memory acking every cycle → exactly 4 pushes (addresses 0,4,8,12); mem_req low with count=4. Raise instr_ready for one cycle → one pop, then a fetch of address 16 is issued.
- redirect=1, redirect_pc=32'h0000_0042 while idle with a non-empty queue → instr_valid=0 next cycle; next mem_addr=32'h0000_0040.
- redirect while REQ is waiting → mem_req stays high at the old address until ack, that data never appears on instr, then mem_addr=redirect_pc.
- redirect in the same cycle as mem_ack → ack data dropped; next request goes to redirect_pc with no DRAIN cycle.
- Redirect to 32'hFFFF_FFFC, ack twice → instr_pc sequence FFFF_FFFC then 0000_0000. Assert reset while mem_req=1 → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: FSM states and the
// queued {instruction word, PC} entry.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush.
// Pointers and count are reset; the entry storage is not.
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t    store [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = store[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues word reads over req/ack, queues returned words with
// their PCs, and flushes everything on a datapath redirect.
module instr_fetch_queue import fetch_pkg::*; #(
  parameter int             n        = 32,
  parameter int             DEPTH    = 4,
  parameter logic [n-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  input  logic         instr_ready,
  output logic [n-1:0] instr,
  output logic [n-1:0] instr_pc,
  output logic         instr_valid,
  output logic         mem_req,
  output logic [n-1:0] mem_addr,
  input  logic [n-1:0] mem_rdata,
  input  logic         mem_ack
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [n-1:0] STEP = n'(WORD_BYTES);

  fetch_state_t   state;
  fetch_state_t   state_nxt;
  logic [n-1:0]   fpc;
  logic [n-1:0]   fpc_nxt;
  logic [n-1:0]   addr_nxt;
  logic [n-1:0]   target_pc;
  logic           push;
  logic           pop;
  logic           flush;
  logic           room_after_push;
  logic [CW-1:0]  count;
  logic           empty;
  logic           full;
  fetch_entry_t   head;
  fetch_entry_t   entry_in;

  assign pop       = instr_valid & instr_ready;
  assign target_pc = word_align(redirect_pc);
  assign entry_in  = '{word: mem_rdata, pc: mem_addr};
  // A push with a simultaneous pop never changes the count, so there is
  // room for another fetch; otherwise the pre-push count must leave a slot.
  assign room_after_push = pop | (count < CW'(DEPTH - 1));

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (entry_in),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc      <= RESET_PC;
      mem_addr <= RESET_PC;
    end else begin
      fpc      <= fpc_nxt;
      mem_addr <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fpc_nxt   = fpc;
    addr_nxt  = mem_addr;
    push      = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          flush   = 1'b1;
          fpc_nxt = target_pc;
        end else if (!full) begin
          state_nxt = REQ;
          addr_nxt  = fpc;
        end
      end
      REQ: begin
        if (redirect) begin
          // Without an ack the request must still be seen through in DRAIN.
          flush     = 1'b1;
          fpc_nxt   = target_pc;
          state_nxt = mem_ack ? IDLE : DRAIN;
        end else if (mem_ack) begin
          push    = 1'b1;
          fpc_nxt = fpc + STEP;
          if (room_after_push) begin
            state_nxt = REQ;
            addr_nxt  = fpc + STEP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        if (redirect) begin
          flush   = 1'b1;
          fpc_nxt = target_pc;
        end
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req     = (state != IDLE);
    instr_valid = ~empty;
    instr       = empty ? '0 : head.word;
    instr_pc    = empty ? '0 : head.pc;
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: per-cycle vector table plus
// hand-written sequences for async reset and repeated redirects in DRAIN.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  always #5 clk = ~clk;

  instr_fetch_queue #(.n(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                              input logic rdy, input logic ack, input logic [31:0] rdata,
                              input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                              input logic [31:0] e_instr, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_instr = e_instr; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                          input logic e_vld, input logic [31:0] e_instr, input logic [31:0] e_pc);
    chk({tag, ".mem_req"},     {31'b0, mem_req},     {31'b0, e_req});
    chk({tag, ".mem_addr"},    mem_addr,             e_addr);
    chk({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, e_vld});
    chk({tag, ".instr"},       instr,                e_instr);
    chk({tag, ".instr_pc"},    instr_pc,             e_pc);
  endtask

  task automatic drive(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic rdy, input logic ack, input logic [31:0] rdata);
    reset = rst; redirect = redir; redirect_pc = rpc;
    instr_ready = rdy; mem_ack = ack; mem_rdata = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Two acks after reset, datapath always ready
    tbl.push_back(mk(1,0,32'h0,1,0,32'h0,          0,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,1,0,32'h0,          1,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,1,0,32'h0,          1,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,1,1,32'h0C0D000F,   1,32'h4,1,32'h0C0D000F,32'h0));
    tbl.push_back(mk(0,0,32'h0,1,0,32'h0,          1,32'h4,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,1,1,32'h0C0D000A,   1,32'h8,1,32'h0C0D000A,32'h4));
    tbl.push_back(mk(0,0,32'h0,1,0,32'h0,          1,32'h8,0,32'h0,32'h0));
    // Fill the queue with acks every cycle, then a single pop
    tbl.push_back(mk(1,0,32'h0,0,0,32'h0,          0,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h0,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,1,32'h1000_0000,  1,32'h4,1,32'h1000_0000,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,1,32'h1000_0001,  1,32'h8,1,32'h1000_0000,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,1,32'h1000_0002,  1,32'hC,1,32'h1000_0000,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,1,32'h1000_0003,  0,32'hC,1,32'h1000_0000,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,0,32'h0,          0,32'hC,1,32'h1000_0000,32'h0));
    tbl.push_back(mk(0,0,32'h0,1,0,32'h0,          0,32'hC,1,32'h1000_0001,32'h4));
    tbl.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h10,1,32'h1000_0001,32'h4));
    // Refill, then redirect while idle with a full queue
    tbl.push_back(mk(0,0,32'h0,0,1,32'h1000_0004,  0,32'h10,1,32'h1000_0001,32'h4));
    tbl.push_back(mk(0,1,32'h42,1,0,32'h0,         0,32'h10,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h40,0,32'h0,32'h0));
    // Redirect while a request waits: drain at the old address
    tbl.push_back(mk(0,1,32'h100,0,0,32'h0,        1,32'h40,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h40,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,1,32'hDEADBEEF,   0,32'h40,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h100,0,32'h0,32'h0));
    // Redirect coincident with ack: data dropped, no drain
    tbl.push_back(mk(0,1,32'h203,0,1,32'h00BADBAD, 0,32'h100,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h200,0,32'h0,32'h0));
    // Fetch PC wraps past the top of the address space
    tbl.push_back(mk(0,1,32'hFFFF_FFFE,0,1,32'h1111_1111, 0,32'h200,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'hFFFF_FFFC,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,1,32'h2000_0000,  1,32'h0,1,32'h2000_0000,32'hFFFF_FFFC));
    tbl.push_back(mk(0,0,32'h0,1,1,32'h2000_0001,  1,32'h4,1,32'h2000_0001,32'h0));

    drive(1, 0, 32'h0, 0, 0, 32'h0);
    repeat (2) step();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rdy, tbl[i].ack, tbl[i].rdata);
      step();
      chk_outs($sformatf("v%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld,
               tbl[i].e_instr, tbl[i].e_pc);
    end

    // Reset mid-request takes effect without a clock edge
    chk("pre_reset.mem_req", {31'b0, mem_req}, 32'h1);
    reset = 1'b1;
    #1;
    chk_outs("async_reset", 0, 32'h0, 0, 32'h0, 32'h0);
    step();
    drive(0, 0, 32'h0, 0, 0, 32'h0);

    // Repeated redirects while draining; the last one coincides with the ack
    step();
    chk_outs("drain_req", 1, 32'h0, 0, 32'h0, 32'h0);
    drive(0, 1, 32'h300, 0, 0, 32'h0);
    step();
    chk_outs("drain_r1", 1, 32'h0, 0, 32'h0, 32'h0);
    drive(0, 1, 32'h400, 0, 0, 32'h0);
    step();
    chk_outs("drain_r2", 1, 32'h0, 0, 32'h0, 32'h0);
    drive(0, 1, 32'h501, 0, 1, 32'h5555_5555);
    step();
    chk_outs("drain_r3_ack", 0, 32'h0, 0, 32'h0, 32'h0);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    step();
    chk_outs("after_drain", 1, 32'h500, 0, 32'h0, 32'h0);
    drive(0, 0, 32'h0, 0, 1, 32'h0000_1234);
    step();
    chk_outs("after_drain_push", 1, 32'h504, 1, 32'h0000_1234, 32'h500);
    drive(0, 0, 32'h0, 0, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
